// File: rtl/debug_pkg.sv
// Shared definitions for the debug loader: FSM state encoding, command bytes
// and the default program terminator word.
package debug_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [7:0] CMD_LOAD  = 8'h4C;
    localparam logic [7:0] CMD_RUN   = 8'h43;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_NEXT  = 8'h4E;
    localparam logic [7:0] CMD_REARM = 8'h52;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/word_assembler.sv
// Collects four bytes into a big-endian 32-bit word. word/word_valid are
// combinational on the fourth byte so the caller registers the write itself.
module word_assembler (
    input  logic        clk,
    input  logic        srst,
    input  logic        clear,
    input  logic        en,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt_reg;
    logic [23:0] shift_reg;

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            cnt_reg   <= 2'd0;
            shift_reg <= 24'd0;
        end else if (en && byte_valid) begin
            shift_reg <= {shift_reg[15:0], byte_data};
            cnt_reg   <= cnt_reg + 2'd1;
        end
    end

    assign word_valid = en && byte_valid && (cnt_reg == 2'd3);
    assign word       = {shift_reg, byte_data};

endmodule

// File: rtl/debug_loader.sv
// UART-driven program loader and run/step controller for the pipeline.
// Loads 32-bit words into instruction memory, then gates the pipeline enable/reset.
module debug_loader
    import debug_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              halted_in,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_enable,
    output logic              cpu_reset,
    output logic              load_ovf,
    output logic [2:0]        state_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state_reg;
    logic              imem_we_reg;
    logic [ADDR_W-1:0] imem_addr_reg;
    logic [31:0]       imem_wdata_reg;
    logic              cpu_enable_reg;
    logic              cpu_reset_reg;
    logic              load_ovf_reg;

    logic              asm_clear;
    logic              word_valid;
    logic [31:0]       word;
    logic              next_cmd;

    assign asm_clear = (state_reg == ST_IDLE) && rx_valid && (rx_data == CMD_LOAD);
    assign next_cmd  = rx_valid && (rx_data == CMD_NEXT);

    word_assembler u_asm (
        .clk        (clk),
        .srst       (reset),
        .clear      (asm_clear),
        .en         (state_reg == ST_LOAD),
        .byte_valid (rx_valid),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            imem_we_reg    <= 1'b0;
            imem_addr_reg  <= '0;
            imem_wdata_reg <= 32'd0;
            cpu_enable_reg <= 1'b0;
            cpu_reset_reg  <= 1'b1;
            load_ovf_reg   <= 1'b0;
        end else begin
            imem_we_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    cpu_enable_reg <= 1'b0;
                    cpu_reset_reg  <= 1'b1;
                    if (rx_valid) begin
                        if (rx_data == CMD_LOAD) begin
                            state_reg     <= ST_LOAD;
                            imem_addr_reg <= '0;
                            load_ovf_reg  <= 1'b0;
                        end else if (rx_data == CMD_RUN) begin
                            state_reg      <= ST_RUN;
                            cpu_reset_reg  <= 1'b0;
                            cpu_enable_reg <= 1'b1;
                        end else if (rx_data == CMD_STEP) begin
                            state_reg     <= ST_STEP;
                            cpu_reset_reg <= 1'b0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (word_valid) begin
                        imem_we_reg    <= 1'b1;
                        imem_wdata_reg <= word;
                    end
                    // Address advances after the write; wrap from LAST_ADDR to 0 is natural.
                    if (imem_we_reg) begin
                        imem_addr_reg <= imem_addr_reg + 1'b1;
                        if (imem_wdata_reg == HALT_WORD) begin
                            state_reg <= ST_IDLE;
                        end else if (imem_addr_reg == LAST_ADDR) begin
                            load_ovf_reg <= 1'b1;
                            state_reg    <= ST_IDLE;
                        end
                    end
                end
                ST_RUN: begin
                    if (halted_in) begin
                        state_reg      <= ST_DONE;
                        cpu_enable_reg <= 1'b0;
                    end
                end
                ST_STEP: begin
                    cpu_enable_reg <= next_cmd && !halted_in;
                    if (next_cmd && halted_in) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    cpu_enable_reg <= 1'b0;
                    if (rx_valid && (rx_data == CMD_REARM)) begin
                        state_reg     <= ST_IDLE;
                        cpu_reset_reg <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Halt must stop the pipeline in the very cycle it is reported.
    assign cpu_enable = cpu_enable_reg && !((state_reg == ST_RUN) && halted_in);
    assign cpu_reset  = cpu_reset_reg;
    assign imem_we    = imem_we_reg;
    assign imem_addr  = imem_addr_reg;
    assign imem_wdata = imem_wdata_reg;
    assign load_ovf   = load_ovf_reg;
    assign state_o    = state_reg;

endmodule
